// File: rtl/sine_lookup_interp.sv
// sine_lookup_interp: pipelined quarter-wave sine/cosine lookup, optional linear interpolation
//   Macro SINE_INTERP_EN: defined -> interpolate between adjacent table points,
//   undefined -> truncating lookup (single ROM port, no multiplier), same latency 5.
//   Ports: clk, reset (async, active-high); in_valid/in_phase/in_cos/in_chan request;
//   out_valid/out_sine (signed OUT_W)/out_chan result, 5 clocks after the request.
//   The quarter table round(PEAK*sin(2*pi*k/2^ADDR_W)), k=0..QN, is built at elaboration.
module sine_lookup_interp #(
  parameter int PHASE_W = 24,
  parameter int ADDR_W  = 11,
  parameter int OUT_W   = 17,
  parameter int CHAN_W  = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [PHASE_W-1:0] in_phase,
  input  logic               in_cos,
  input  logic [CHAN_W-1:0]  in_chan,
  output logic               out_valid,
  output logic [OUT_W-1:0]   out_sine,
  output logic [CHAN_W-1:0]  out_chan
);
  localparam int FRAC_W = PHASE_W - ADDR_W;
  localparam int QN     = 1 << (ADDR_W - 2);
  localparam int A_W    = ADDR_W - 1;
  localparam longint PEAK = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;
  localparam longint TWO_PI_Q30 = 64'sd6746518852;
  // Q30 fixed-point Taylor series; accurate far below one output LSB for x <= pi/2
  function automatic logic [OUT_W-2:0] quarter_sin(input int k);
    longint x, t, s, v;
    x = TWO_PI_Q30 * longint'(k) / longint'(4 * QN);
    t = x;
    s = x;
    for (int n = 1; n < 8; n++) begin
      t = -((((t * x) >>> 30) * x) >>> 30) / longint'(2 * n * (2 * n + 1));
      s = s + t;
    end
    v = (s * PEAK + (64'sd1 <<< 29)) >>> 30;
    v = v > PEAK ? PEAK : (v < 0 ? 64'sd0 : v);
    return (OUT_W-1)'(v);
  endfunction
  // odd quadrants read the table mirrored: QN-k
  function automatic logic [A_W-1:0] rom_addr(input logic [ADDR_W-1:0] i);
    logic [A_W-1:0] k;
    k = {1'b0, i[ADDR_W-3:0]};
    return i[ADDR_W-2] ? A_W'(QN) - k : k;
  endfunction
  logic [OUT_W-2:0] rom [QN+1];
  genvar g;
  for (g = 0; g <= QN; g++) begin : g_rom
    localparam logic [OUT_W-2:0] V = quarter_sin(g);
    assign rom[g] = V;
  end
  logic [4:0]              v_d, v_q;
  logic [CHAN_W-1:0]       ch_d [5], ch_q [5];
  logic [ADDR_W-1:0]       idx_d, idx_q;
  logic [A_W-1:0]          a0_d, a0_q;
  logic [1:0]              neg0_d, neg0_q;
  logic [OUT_W-2:0]        t0_d, t0_q;
  logic [OUT_W-1:0]        s0_d, s0_q, s0x_d, s0x_q;
  logic                    out_valid_d, out_valid_q;
  logic [OUT_W-1:0]        out_sine_d, out_sine_q;
  logic [CHAN_W-1:0]       out_chan_d, out_chan_q;
`ifdef SINE_INTERP_EN
  localparam int M_W = OUT_W + 1 + FRAC_W;
  logic [FRAC_W-1:0]       frac_d [4], frac_q [4];
  logic [ADDR_W-1:0]       idx1;
  logic [A_W-1:0]          a1_d, a1_q;
  logic [1:0]              neg1_d, neg1_q;
  logic [OUT_W-2:0]        t1_d, t1_q;
  logic [OUT_W-1:0]        s1_d, s1_q;
  logic [OUT_W:0]          diff;
  logic [M_W-1:0]          m_d, m_q;
  logic                    m_sign_unused;
`else
  logic                    frac_unused;
`endif
  always_comb begin
    v_d = {v_q[3:0], in_valid};
    ch_d[0] = in_chan;
    for (int i = 1; i < 5; i++) ch_d[i] = ch_q[i-1];
    // a quarter turn only touches the table-index bits of the phase
    idx_d = in_phase[PHASE_W-1 -: ADDR_W] + (in_cos ? ADDR_W'(QN) : '0);
    a0_d = rom_addr(idx_q);
    neg0_d = {neg0_q[0], idx_q[ADDR_W-1]};
    t0_d = rom[a0_q];
    s0_d = neg0_q[1] ? -{1'b0, t0_q} : {1'b0, t0_q};
    s0x_d = s0_q;
    out_valid_d = v_q[4];
    out_chan_d = v_q[4] ? ch_q[4] : out_chan_q;
`ifdef SINE_INTERP_EN
    frac_d[0] = in_phase[FRAC_W-1:0];
    for (int i = 1; i < 4; i++) frac_d[i] = frac_q[i-1];
    idx1 = idx_q + ADDR_W'(1);
    a1_d = rom_addr(idx1);
    neg1_d = {neg1_q[0], idx1[ADDR_W-1]};
    t1_d = rom[a1_q];
    s1_d = neg1_q[1] ? -{1'b0, t1_q} : {1'b0, t1_q};
    diff = {s1_q[OUT_W-1], s1_q} - {s0_q[OUT_W-1], s0_q};
    // low M_W bits of an unsigned product equal the signed product
    m_d = {{FRAC_W{diff[OUT_W]}}, diff} * {{(OUT_W+1){1'b0}}, frac_q[3]};
    // the floored quotient always fits OUT_W bits, so the top bit is redundant
    m_sign_unused = m_q[M_W-1];
    out_sine_d = v_q[4] ? s0x_q + m_q[FRAC_W +: OUT_W] : out_sine_q;
`else
    frac_unused = ^in_phase[FRAC_W-1:0];
    out_sine_d = v_q[4] ? s0x_q : out_sine_q;
`endif
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q <= '0;
      ch_q <= '{default: '0};
      idx_q <= '0;
      a0_q <= '0;
      neg0_q <= '0;
      t0_q <= '0;
      s0_q <= '0;
      s0x_q <= '0;
      out_valid_q <= 1'b0;
      out_sine_q <= '0;
      out_chan_q <= '0;
`ifdef SINE_INTERP_EN
      frac_q <= '{default: '0};
      a1_q <= '0;
      neg1_q <= '0;
      t1_q <= '0;
      s1_q <= '0;
      m_q <= '0;
`endif
    end else begin
      v_q <= v_d;
      ch_q <= ch_d;
      idx_q <= idx_d;
      a0_q <= a0_d;
      neg0_q <= neg0_d;
      t0_q <= t0_d;
      s0_q <= s0_d;
      s0x_q <= s0x_d;
      out_valid_q <= out_valid_d;
      out_sine_q <= out_sine_d;
      out_chan_q <= out_chan_d;
`ifdef SINE_INTERP_EN
      frac_q <= frac_d;
      a1_q <= a1_d;
      neg1_q <= neg1_d;
      t1_q <= t1_d;
      s1_q <= s1_d;
      m_q <= m_d;
`endif
    end
  end
  assign out_valid = out_valid_q;
  assign out_sine  = out_sine_q;
  assign out_chan  = out_chan_q;
endmodule

// File: tb/tb_sine_lookup_interp.sv
// tb_sine_lookup_interp: directed self-checking bench for sine_lookup_interp
module tb_sine_lookup_interp;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [23:0] in_phase = '0;
  logic        in_cos = 1'b0;
  logic [6:0]  in_chan = '0;
  logic        out_valid;
  logic [16:0] out_sine;
  logic [6:0]  out_chan;
  int n_checks = 0;
  int n_fail = 0;
  int res [4096];
  sine_lookup_interp dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_phase(in_phase),
    .in_cos(in_cos), .in_chan(in_chan), .out_valid(out_valid),
    .out_sine(out_sine), .out_chan(out_chan)
  );
  always #5 clk = ~clk;
  task automatic drive(input logic v, input logic [23:0] p, input logic c, input logic [6:0] ch);
    @(negedge clk);
    in_valid = v;
    in_phase = p;
    in_cos = c;
    in_chan = ch;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    repeat (3) tick;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_sine !== 17'd0) begin n_fail++; $display("FAIL reset_sine: got %0d expected 0", out_sine); end
    n_checks++; if (out_chan !== 7'd0) begin n_fail++; $display("FAIL reset_chan: got %0d expected 0", out_chan); end
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic test_quadrants;
    logic [23:0] ph [4] = '{24'h000000, 24'h400000, 24'h800000, 24'hC00000};
    int ex [4] = '{0, 65535, 0, -65535};
    for (int i = 0; i < 4; i++) begin drive(1, ph[i], 0, 7'd3); tick; end
    drive(0, 0, 0, 0);
    tick;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL quad_early_valid: got %b expected 0", out_valid); end
    for (int i = 0; i < 4; i++) begin
      tick;
      n_checks++; if (out_valid !== 1'b1 || int'($signed(out_sine)) != ex[i] || out_chan !== 7'd3) begin
        n_fail++; $display("FAIL quad_%0d: got v=%b s=%0d c=%0d expected v=1 s=%0d c=3", i, out_valid, $signed(out_sine), out_chan, ex[i]);
      end
    end
  endtask
  task automatic test_cosine;
    int ex [2] = '{65535, 0};
    drive(1, 24'h000000, 1, 7'd5); tick;
    drive(1, 24'hC00000, 1, 7'd6); tick;
    drive(0, 0, 0, 0);
    repeat (3) tick;
    for (int i = 0; i < 2; i++) begin
      tick;
      n_checks++; if (out_valid !== 1'b1 || int'($signed(out_sine)) != ex[i] || int'(out_chan) != 5 + i) begin
        n_fail++; $display("FAIL cos_%0d: got v=%b s=%0d c=%0d expected v=1 s=%0d c=%0d", i, out_valid, $signed(out_sine), out_chan, ex[i], 5 + i);
      end
    end
  endtask
  task automatic test_interp;
`ifdef SINE_INTERP_EN
    int ex [2] = '{100, -101};
`else
    int ex [2] = '{0, -201};
`endif
    drive(1, 24'h001000, 0, 7'd10); tick;
    drive(1, 24'hFFF000, 0, 7'd11); tick;
    drive(0, 0, 0, 0);
    repeat (3) tick;
    for (int i = 0; i < 2; i++) begin
      tick;
      n_checks++; if (out_valid !== 1'b1 || int'($signed(out_sine)) != ex[i] || int'(out_chan) != 10 + i) begin
        n_fail++; $display("FAIL interp_%0d: got v=%b s=%0d c=%0d expected v=1 s=%0d c=%0d", i, out_valid, $signed(out_sine), out_chan, ex[i], 10 + i);
      end
    end
  endtask
  task automatic test_back_to_back;
    logic ev [3] = '{1'b1, 1'b0, 1'b1};
    int es [3] = '{65535, 65535, -65535};
    int ec [3] = '{1, 1, 2};
    drive(1, 24'h400000, 0, 7'd1); tick;
    drive(0, 24'h800000, 0, 7'd9); tick;
    drive(1, 24'hC00000, 0, 7'd2); tick;
    drive(0, 0, 0, 0);
    repeat (2) tick;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_checks++; if (out_valid !== ev[i] || int'($signed(out_sine)) != es[i] || int'(out_chan) != ec[i]) begin
        n_fail++; $display("FAIL b2b_%0d: got v=%b s=%0d c=%0d expected v=%b s=%0d c=%0d", i, out_valid, $signed(out_sine), out_chan, ev[i], es[i], ec[i]);
      end
    end
  endtask
  task automatic test_reset_mid;
    for (int i = 0; i < 4; i++) begin drive(1, 24'h400000, 0, 7'(20 + i)); tick; end
    drive(0, 0, 0, 0);
    repeat (2) tick;
    n_checks++; if (out_valid !== 1'b1 || int'($signed(out_sine)) != 65535) begin
      n_fail++; $display("FAIL rst_mid_pre: got v=%b s=%0d expected v=1 s=65535", out_valid, $signed(out_sine));
    end
    #1 reset = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_sine !== 17'd0 || out_chan !== 7'd0) begin
      n_fail++; $display("FAIL rst_mid_async: got v=%b s=%0d c=%0d expected all 0", out_valid, out_sine, out_chan);
    end
    #1 reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stale_%0d: got %b expected 0", i, out_valid); end
    end
    drive(1, 24'h400000, 0, 7'd30); tick;
    drive(0, 0, 0, 0);
    repeat (4) tick;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_early: got %b expected 0", out_valid); end
    tick;
    n_checks++; if (out_valid !== 1'b1 || int'($signed(out_sine)) != 65535 || out_chan !== 7'd30) begin
      n_fail++; $display("FAIL rst_mid_after: got v=%b s=%0d c=%0d expected v=1 s=65535 c=30", out_valid, $signed(out_sine), out_chan);
    end
  endtask
  task automatic test_sweep;
    real y, e, tol;
    int r;
    for (int j = 0; j < 4096 + 5; j++) begin
      drive(j < 4096, 24'(j * 4096), 0, 7'(j));
      tick;
      if (j >= 5) begin
        r = j - 5;
        res[r] = int'($signed(out_sine));
        n_checks++; if (out_valid !== 1'b1 || out_chan !== 7'(r)) begin
          n_fail++; $display("FAIL sweep_tag_%0d: got v=%b c=%0d expected v=1 c=%0d", r, out_valid, out_chan, r % 128);
        end
        y = 65535.0 * $sin(6.283185307179586 * real'(r) / 4096.0);
        e = real'(res[r]) - y;
        if (e < 0.0) e = -e;
`ifdef SINE_INTERP_EN
        tol = 2.0;
`else
        tol = (r % 2 == 0) ? 1.0 : 102.0;
`endif
        n_checks++; if (e > tol) begin
          n_fail++; $display("FAIL sweep_val_%0d: got %0d expected %f within %f", r, res[r], y, tol);
        end
      end
    end
    for (int i = 0; i < 2048; i++) begin
`ifdef SINE_INTERP_EN
      tol = 1.0;
`else
      tol = 0.0;
`endif
      e = real'(res[i] + res[i + 2048]);
      if (e < 0.0) e = -e;
      n_checks++; if (e > tol) begin
        n_fail++; $display("FAIL sweep_sym_%0d: got %0d and %0d expected negatives", i, res[i], res[i + 2048]);
      end
    end
  endtask
  initial begin
    test_reset;
    test_quadrants;
    test_cosine;
    test_interp;
    test_back_to_back;
    test_reset_mid;
    test_sweep;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
